buffet_write_arbiter: RTL and testbench



---
 rtl/buffet_write_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_buffet_write_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buffet_write_arbiter.sv
// buffet_write_arbiter
//
// Shares the single buffet storage write port between the push path and the
// update (read-modify-write) path. Pushes wait in an in-order FIFO. Updates
// win by static priority. A starvation counter forces one push grant after
// STARVE_LIMIT consecutive update grants made while pushes were waiting.
// A committed update produces a one-cycle retire pulse that carries its index.
//
// Optional feature macro: BUFFET_WR_ARB_STATS_EN builds the saturating grant
// statistics counters. When it is undefined the stat ports are tied to zero.
//
// Ports:
//   clk, reset_i                     clock, synchronous active-high reset
//   push_data_i/idx_i/valid_i        push request
//   push_ready_o                     push FIFO has a free slot
//   update_data_i/idx_i/valid_i      update request
//   update_ready_o                   update granted this cycle
//   wr_data_o/idx_o/valid_o          storage write request (registered)
//   wr_ready_i                       storage accepts the write
//   update_done_o/update_done_idx_o  retire pulse and retired index
//   fifo_count_o                     push FIFO occupancy
//   stat_*_cnt_o                     push / update / forced grant counters
module buffet_write_arbiter #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned PUSH_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT    = 8
) (
  input  logic                               clk,
  input  logic                               reset_i,
  input  logic [DATA_WIDTH-1:0]              push_data_i,
  input  logic [ADDR_WIDTH-1:0]              push_idx_i,
  input  logic                               push_valid_i,
  output logic                               push_ready_o,
  input  logic [DATA_WIDTH-1:0]              update_data_i,
  input  logic [ADDR_WIDTH-1:0]              update_idx_i,
  input  logic                               update_valid_i,
  output logic                               update_ready_o,
  output logic [DATA_WIDTH-1:0]              wr_data_o,
  output logic [ADDR_WIDTH-1:0]              wr_idx_o,
  output logic                               wr_valid_o,
  input  logic                               wr_ready_i,
  output logic                               update_done_o,
  output logic [ADDR_WIDTH-1:0]              update_done_idx_o,
  output logic [$clog2(PUSH_FIFO_DEPTH):0]   fifo_count_o,
  output logic [15:0]                        stat_push_cnt_o,
  output logic [15:0]                        stat_update_cnt_o,
  output logic [15:0]                        stat_forced_cnt_o
);

  localparam int unsigned PtrW    = $clog2(PUSH_FIFO_DEPTH);
  localparam int unsigned CntW    = PtrW + 1;
  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);

  // Push FIFO
  logic [DATA_WIDTH-1:0] fifo_data_q [PUSH_FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_idx_q  [PUSH_FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]       count_q, count_d;

  // Output stage
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [ADDR_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_is_upd_q, out_is_upd_d;

  // Retire
  logic                  done_q, done_d;
  logic [ADDR_WIDTH-1:0] done_idx_q, done_idx_d;

  logic [StarveW-1:0]    starve_cnt_q, starve_cnt_d;

  logic enq, load_en, fifo_nonempty, force_push;
  logic grant_update, grant_push, commit;

  assign fifo_nonempty = (count_q != '0);
  // Readiness uses the current count only; a same-cycle dequeue frees nothing.
  assign push_ready_o  = (count_q != CntW'(PUSH_FIFO_DEPTH));
  assign enq           = push_valid_i & push_ready_o;

  assign load_en    = ~out_valid_q | wr_ready_i;
  assign force_push = fifo_nonempty & (starve_cnt_q == StarveW'(STARVE_LIMIT));
  // No grants while reset is asserted so update_ready_o reads 0 in reset.
  assign grant_update = ~reset_i & load_en & update_valid_i & ~force_push;
  assign grant_push   = ~reset_i & load_en & ~grant_update & fifo_nonempty;
  assign commit       = out_valid_q & wr_ready_i;

  assign update_ready_o = grant_update;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (grant_push) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    count_d = count_q + CntW'(enq) - CntW'(grant_push);
  end

  always_comb begin
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_valid_d  = out_valid_q;
    out_is_upd_d = out_is_upd_q;
    if (load_en) begin
      if (grant_update) begin
        out_data_d   = update_data_i;
        out_idx_d    = update_idx_i;
        out_valid_d  = 1'b1;
        out_is_upd_d = 1'b1;
      end else if (grant_push) begin
        out_data_d   = fifo_data_q[rd_ptr_q];
        out_idx_d    = fifo_idx_q[rd_ptr_q];
        out_valid_d  = 1'b1;
        out_is_upd_d = 1'b0;
      end else begin
        out_valid_d  = 1'b0;
        out_is_upd_d = 1'b0;
      end
    end
  end

  always_comb begin
    done_d     = commit & out_is_upd_q;
    done_idx_d = done_idx_q;
    if (commit && out_is_upd_q) begin
      done_idx_d = out_idx_q;
    end
  end

  // Counts update grants only while pushes are actually waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!fifo_nonempty || grant_push) begin
      starve_cnt_d = '0;
    end else if (grant_update) begin
      starve_cnt_d = starve_cnt_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_valid_q  <= 1'b0;
      out_is_upd_q <= 1'b0;
      done_q       <= 1'b0;
      done_idx_q   <= '0;
      starve_cnt_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_valid_q  <= out_valid_d;
      out_is_upd_q <= out_is_upd_d;
      done_q       <= done_d;
      done_idx_q   <= done_idx_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Storage needs no reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (enq && !reset_i) begin
      fifo_data_q[wr_ptr_q] <= push_data_i;
      fifo_idx_q[wr_ptr_q]  <= push_idx_i;
    end
  end

  assign wr_data_o         = out_data_q;
  assign wr_idx_o          = out_idx_q;
  assign wr_valid_o        = out_valid_q;
  assign update_done_o     = done_q;
  assign update_done_idx_o = done_idx_q;
  assign fifo_count_o      = count_q;

`ifdef BUFFET_WR_ARB_STATS_EN
  logic [15:0] stat_push_q, stat_update_q, stat_forced_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      stat_push_q   <= '0;
      stat_update_q <= '0;
      stat_forced_q <= '0;
    end else begin
      if (grant_push && stat_push_q != 16'hFFFF) begin
        stat_push_q <= stat_push_q + 16'd1;
      end
      if (grant_update && stat_update_q != 16'hFFFF) begin
        stat_update_q <= stat_update_q + 16'd1;
      end
      // force_push blocks updates, so a forced grant is always a push grant.
      if (grant_push && force_push && stat_forced_q != 16'hFFFF) begin
        stat_forced_q <= stat_forced_q + 16'd1;
      end
    end
  end

  assign stat_push_cnt_o   = stat_push_q;
  assign stat_update_cnt_o = stat_update_q;
  assign stat_forced_cnt_o = stat_forced_q;
`else
  assign stat_push_cnt_o   = '0;
  assign stat_update_cnt_o = '0;
  assign stat_forced_cnt_o = '0;
`endif

endmodule

// File: tb/tb_buffet_write_arbiter.sv
module tb_buffet_write_arbiter;

  logic        clk;
  logic        reset_i;
  logic [31:0] push_data_i;
  logic [7:0]  push_idx_i;
  logic        push_valid_i;
  logic        push_ready_o;
  logic [31:0] update_data_i;
  logic [7:0]  update_idx_i;
  logic        update_valid_i;
  logic        update_ready_o;
  logic [31:0] wr_data_o;
  logic [7:0]  wr_idx_o;
  logic        wr_valid_o;
  logic        wr_ready_i;
  logic        update_done_o;
  logic [7:0]  update_done_idx_o;
  logic [2:0]  fifo_count_o;
  logic [15:0] stat_push_cnt_o;
  logic [15:0] stat_update_cnt_o;
  logic [15:0] stat_forced_cnt_o;

  int checks = 0;
  int errors = 0;

  buffet_write_arbiter #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (8),
    .PUSH_FIFO_DEPTH(4),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .push_data_i      (push_data_i),
    .push_idx_i       (push_idx_i),
    .push_valid_i     (push_valid_i),
    .push_ready_o     (push_ready_o),
    .update_data_i    (update_data_i),
    .update_idx_i     (update_idx_i),
    .update_valid_i   (update_valid_i),
    .update_ready_o   (update_ready_o),
    .wr_data_o        (wr_data_o),
    .wr_idx_o         (wr_idx_o),
    .wr_valid_o       (wr_valid_o),
    .wr_ready_i       (wr_ready_i),
    .update_done_o    (update_done_o),
    .update_done_idx_o(update_done_idx_o),
    .fifo_count_o     (fifo_count_o),
    .stat_push_cnt_o  (stat_push_cnt_o),
    .stat_update_cnt_o(stat_update_cnt_o),
    .stat_forced_cnt_o(stat_forced_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic push(input logic [7:0] idx, input logic [31:0] data);
    push_valid_i = 1'b1;
    push_idx_i   = idx;
    push_data_i  = data;
  endtask

  task automatic update(input logic [7:0] idx, input logic [31:0] data);
    update_valid_i = 1'b1;
    update_idx_i   = idx;
    update_data_i  = data;
  endtask

  initial begin
    reset_i        = 1'b1;
    push_data_i    = '0;
    push_idx_i     = '0;
    push_valid_i   = 1'b0;
    update_data_i  = '0;
    update_idx_i   = '0;
    update_valid_i = 1'b0;
    wr_ready_i     = 1'b1;
    tick();
    tick();
    settle();
    // Reset values
    chk("rst_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("rst_done", 64'(update_done_o), 64'd0);
    chk("rst_upd_ready", 64'(update_ready_o), 64'd0);
    chk("rst_push_ready", 64'(push_ready_o), 64'd1);
    chk("rst_fifo_count", 64'(fifo_count_o), 64'd0);
    chk("rst_wr_data", 64'(wr_data_o), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx_o), 64'd0);
    chk("rst_done_idx", 64'(update_done_idx_o), 64'd0);
    chk("rst_stat_push", 64'(stat_push_cnt_o), 64'd0);
    chk("rst_stat_upd", 64'(stat_update_cnt_o), 64'd0);
    chk("rst_stat_forced", 64'(stat_forced_cnt_o), 64'd0);
    reset_i = 1'b0;
    tick();

    // Push latency: push in cycle 0, write visible in cycle 2
    push(8'd3, 32'hA5);
    settle();
    chk("t1_push_ready", 64'(push_ready_o), 64'd1);
    tick();
    push_valid_i = 1'b0;
    settle();
    chk("t1_c1_count", 64'(fifo_count_o), 64'd1);
    chk("t1_c1_wr_valid", 64'(wr_valid_o), 64'd0);
    tick();
    settle();
    chk("t1_c2_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t1_c2_wr_idx", 64'(wr_idx_o), 64'd3);
    chk("t1_c2_wr_data", 64'(wr_data_o), 64'hA5);
    chk("t1_c2_count", 64'(fifo_count_o), 64'd0);
    chk("t1_c2_done", 64'(update_done_o), 64'd0);
    tick();
    settle();
    chk("t1_c3_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("t1_c3_done", 64'(update_done_o), 64'd0);

    // Update retire
    update(8'd7, 32'h11);
    settle();
    chk("t2_upd_ready", 64'(update_ready_o), 64'd1);
    tick();
    update_valid_i = 1'b0;
    settle();
    chk("t2_c1_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t2_c1_wr_idx", 64'(wr_idx_o), 64'd7);
    chk("t2_c1_wr_data", 64'(wr_data_o), 64'h11);
    chk("t2_c1_done", 64'(update_done_o), 64'd0);
    tick();
    settle();
    chk("t2_c2_done", 64'(update_done_o), 64'd1);
    chk("t2_c2_done_idx", 64'(update_done_idx_o), 64'd7);
    chk("t2_c2_wr_valid", 64'(wr_valid_o), 64'd0);
    tick();
    settle();
    chk("t2_c3_done", 64'(update_done_o), 64'd0);

    // Starvation: push enters empty FIFO alongside an update (no starve count
    // that cycle), then 8 update grants while it waits, then a forced push.
    push(8'd9, 32'h99);
    update(8'd1, 32'h100);
    settle();
    chk("t3_c0_upd_ready", 64'(update_ready_o), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      push_valid_i  = 1'b0;
      update_data_i = 32'h100 + 32'(i);
      settle();
      chk($sformatf("t3_c%0d_upd_ready", i), 64'(update_ready_o), 64'd1);
      chk($sformatf("t3_c%0d_count", i), 64'(fifo_count_o), 64'd1);
      chk($sformatf("t3_c%0d_wr_data", i), 64'(wr_data_o), 64'h100 + 64'(i - 1));
    end
    tick();
    settle();
    chk("t3_c9_upd_ready", 64'(update_ready_o), 64'd0);
    chk("t3_c9_wr_data", 64'(wr_data_o), 64'h108);
    tick();
    update_data_i = 32'h200;
    settle();
    chk("t3_c10_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t3_c10_wr_idx", 64'(wr_idx_o), 64'd9);
    chk("t3_c10_wr_data", 64'(wr_data_o), 64'h99);
    chk("t3_c10_upd_ready", 64'(update_ready_o), 64'd1);
    chk("t3_c10_count", 64'(fifo_count_o), 64'd0);
    tick();
    update_valid_i = 1'b0;
    settle();
    chk("t3_c11_wr_data", 64'(wr_data_o), 64'h200);
    chk("t3_c11_done", 64'(update_done_o), 64'd0);
    tick();
    settle();
    chk("t3_c12_done", 64'(update_done_o), 64'd1);
    chk("t3_c12_done_idx", 64'(update_done_idx_o), 64'd1);
    tick();

    // FIFO full and backpressure with an update parked at the output
    wr_ready_i = 1'b0;
    update(8'h20, 32'hDEAD);
    settle();
    chk("t4_c0_upd_ready", 64'(update_ready_o), 64'd1);
    tick();
    update_valid_i = 1'b0;
    push(8'h30, 32'h300);
    settle();
    chk("t4_c1_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t4_c1_push_ready", 64'(push_ready_o), 64'd1);
    tick();
    push(8'h31, 32'h301);
    tick();
    push(8'h32, 32'h302);
    tick();
    push(8'h33, 32'h303);
    settle();
    chk("t4_c4_push_ready", 64'(push_ready_o), 64'd1);
    tick();
    push(8'h34, 32'h304);
    settle();
    chk("t4_c5_push_ready", 64'(push_ready_o), 64'd0);
    chk("t4_c5_count", 64'(fifo_count_o), 64'd4);
    chk("t4_c5_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t4_c5_wr_idx", 64'(wr_idx_o), 64'h20);
    chk("t4_c5_wr_data", 64'(wr_data_o), 64'hDEAD);
    chk("t4_c5_done", 64'(update_done_o), 64'd0);
    tick();
    push_valid_i = 1'b0;
    wr_ready_i   = 1'b1;
    settle();
    chk("t4_c6_count", 64'(fifo_count_o), 64'd4);
    chk("t4_c6_wr_idx", 64'(wr_idx_o), 64'h20);
    tick();
    settle();
    chk("t4_c7_wr_idx", 64'(wr_idx_o), 64'h30);
    chk("t4_c7_wr_data", 64'(wr_data_o), 64'h300);
    chk("t4_c7_done", 64'(update_done_o), 64'd1);
    chk("t4_c7_done_idx", 64'(update_done_idx_o), 64'h20);
    chk("t4_c7_count", 64'(fifo_count_o), 64'd3);
    tick();
    settle();
    chk("t4_c8_wr_data", 64'(wr_data_o), 64'h301);
    chk("t4_c8_done", 64'(update_done_o), 64'd0);
    tick();
    settle();
    chk("t4_c9_wr_data", 64'(wr_data_o), 64'h302);
    tick();
    settle();
    chk("t4_c10_wr_data", 64'(wr_data_o), 64'h303);
    chk("t4_c10_wr_valid", 64'(wr_valid_o), 64'd1);
    chk("t4_c10_count", 64'(fifo_count_o), 64'd0);
    tick();
    settle();
    chk("t4_c11_wr_valid", 64'(wr_valid_o), 64'd0);

    // Reset mid-operation
    wr_ready_i = 1'b0;
    update(8'h44, 32'h4444);
    tick();
    update_valid_i = 1'b0;
    push(8'h50, 32'h500);
    tick();
    push(8'h51, 32'h501);
    tick();
    push(8'h52, 32'h502);
    tick();
    push_valid_i = 1'b0;
    settle();
    chk("t5_pre_count", 64'(fifo_count_o), 64'd3);
    chk("t5_pre_wr_valid", 64'(wr_valid_o), 64'd1);
    reset_i = 1'b1;
    tick();
    reset_i    = 1'b0;
    wr_ready_i = 1'b1;
    settle();
    chk("t5_wr_valid", 64'(wr_valid_o), 64'd0);
    chk("t5_count", 64'(fifo_count_o), 64'd0);
    chk("t5_push_ready", 64'(push_ready_o), 64'd1);
    chk("t5_done", 64'(update_done_o), 64'd0);
    chk("t5_stat_forced", 64'(stat_forced_cnt_o), 64'd0);
    tick();
    settle();
    chk("t5_next_done", 64'(update_done_o), 64'd0);
    chk("t5_next_wr_valid", 64'(wr_valid_o), 64'd0);

    // Stats: 3 push grants and 2 update grants, none forced
    push(8'd1, 32'h1);
    update(8'd2, 32'h2);
    tick();
    push(8'd3, 32'h3);
    update(8'd4, 32'h4);
    settle();
    chk("t6_c1_wr_idx", 64'(wr_idx_o), 64'd2);
    tick();
    push(8'd5, 32'h5);
    update_valid_i = 1'b0;
    settle();
    chk("t6_c2_wr_idx", 64'(wr_idx_o), 64'd4);
    tick();
    push_valid_i = 1'b0;
    settle();
    chk("t6_c3_wr_idx", 64'(wr_idx_o), 64'd1);
    tick();
    settle();
    chk("t6_c4_wr_idx", 64'(wr_idx_o), 64'd3);
    tick();
    settle();
    chk("t6_c5_wr_idx", 64'(wr_idx_o), 64'd5);
    tick();
    settle();
    chk("t6_c6_wr_valid", 64'(wr_valid_o), 64'd0);
`ifdef BUFFET_WR_ARB_STATS_EN
    chk("t6_stat_push", 64'(stat_push_cnt_o), 64'd3);
    chk("t6_stat_upd", 64'(stat_update_cnt_o), 64'd2);
    chk("t6_stat_forced", 64'(stat_forced_cnt_o), 64'd0);
`else
    chk("t6_stat_push", 64'(stat_push_cnt_o), 64'd0);
    chk("t6_stat_upd", 64'(stat_update_cnt_o), 64'd0);
    chk("t6_stat_forced", 64'(stat_forced_cnt_o), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
